pic_cascade_ack: RTL and testbench

//  Interrupt-acknowledge sequencer between the master/slave 8259 pair and the CPU core.

---
 rtl/pic_cascade_ack_if.sv | 26 ++
 rtl/pic_cascade_ack.sv | 70 +++++++
 tb/tb_pic_cascade_ack.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pic_cascade_ack_if.sv
// pic_cascade_ack_if: PIC-side and CPU-side signals of the cascade acknowledge sequencer
interface pic_cascade_ack_if #(
   parameter int SPUR_CNT_W = 8
);
   logic                  cpu_if;
   logic                  m_irq_valid;
   logic [7:0]            m_irq_data;
   logic                  m_slave_active;
   logic                  m_irq_ack;
   logic                  s_irq_valid;
   logic [7:0]            s_irq_data;
   logic                  s_irq_ack;
   logic                  cpu_int_valid;
   logic [7:0]            cpu_int_vector;
   logic                  cpu_int_ready;
   logic                  busy;
   logic [SPUR_CNT_W-1:0] spurious_cnt;
   modport master (
      input  cpu_if, m_irq_valid, m_irq_data, m_slave_active, s_irq_valid, s_irq_data, cpu_int_ready,
      output m_irq_ack, s_irq_ack, cpu_int_valid, cpu_int_vector, busy, spurious_cnt
   );
   modport slave (
      output cpu_if, m_irq_valid, m_irq_data, m_slave_active, s_irq_valid, s_irq_data, cpu_int_ready,
      input  m_irq_ack, s_irq_ack, cpu_int_valid, cpu_int_vector, busy, spurious_cnt
   );
endinterface

// File: rtl/pic_cascade_ack.sv
// pic_cascade_ack: interrupt-acknowledge sequencer for a cascaded 8259 pair; PIC_CASCADE_TIMEOUT_EN enables the slave-timeout spurious path
module pic_cascade_ack #(
   parameter int TIMEOUT    = 16,
   parameter int SPUR_CNT_W = 8
) (
   input logic               clk,
   input logic               resetn,
   pic_cascade_ack_if.master bus
);
   typedef enum logic [1:0] {IDLE, WAIT_SLAVE, PRESENT} state_t;
   state_t     state_q;
   logic [7:0] vec_q;
   logic       valid_q;
   logic       take_m, casc, abort, slave_go, spur_go;
`ifdef PIC_CASCADE_TIMEOUT_EN
   logic [7:0]            timer_q;
   logic [SPUR_CNT_W-1:0] spur_q;
`endif
   // Decode the transition firing this cycle; acks are taken straight from it so they align with the PIC's registered data
   always_comb begin
      take_m   = state_q == IDLE && bus.m_irq_valid && bus.cpu_if && !bus.m_slave_active;
      casc     = state_q == IDLE && bus.m_irq_valid && bus.cpu_if && bus.m_slave_active;
      abort    = state_q == WAIT_SLAVE && (!bus.m_irq_valid || !bus.m_slave_active);
      slave_go = state_q == WAIT_SLAVE && !abort && bus.s_irq_valid;
`ifdef PIC_CASCADE_TIMEOUT_EN
      spur_go  = state_q == WAIT_SLAVE && !abort && !bus.s_irq_valid && timer_q == 8'(TIMEOUT - 1);
`else
      spur_go  = 1'b0;
`endif
   end
   assign bus.m_irq_ack      = take_m | slave_go | spur_go;
   assign bus.s_irq_ack      = slave_go;
   assign bus.cpu_int_valid  = valid_q;
   assign bus.cpu_int_vector = vec_q;
   assign bus.busy           = state_q != IDLE;
   // Sequencer: latch the vector on ack, hold it until the CPU takes it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         vec_q   <= 8'h00;
         valid_q <= 1'b0;
      end else if (take_m || slave_go || spur_go) begin
         state_q <= PRESENT;
         valid_q <= 1'b1;
         vec_q   <= take_m ? bus.m_irq_data : slave_go ? bus.s_irq_data : {bus.s_irq_data[7:3], 3'b111};
      end else if (casc) begin
         state_q <= WAIT_SLAVE;
      end else if (abort) begin
         state_q <= IDLE;
      end else if (state_q == PRESENT && bus.cpu_int_ready) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
      end
   end
`ifdef PIC_CASCADE_TIMEOUT_EN
   // Slave-answer timer and saturating spurious counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer_q <= 8'd0;
         spur_q  <= '0;
      end else begin
         timer_q <= casc ? 8'd0 : (state_q == WAIT_SLAVE && !abort && !slave_go && !spur_go) ? timer_q + 8'd1 : timer_q;
         if (spur_go && spur_q != '1) spur_q <= spur_q + 1'b1;
      end
   end
   assign bus.spurious_cnt = spur_q;
`else
   assign bus.spurious_cnt = '0;
`endif
endmodule

// File: tb/tb_pic_cascade_ack.sv
// tb_pic_cascade_ack: directed scenarios plus sticky random stimulus against a cycle-level reference model
module tb_pic_cascade_ack;
   localparam int TIMEOUT = 16;
   localparam int SW      = 8;
`ifdef PIC_CASCADE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;
   pic_cascade_ack_if #(.SPUR_CNT_W(SW)) bus();
   pic_cascade_ack #(.TIMEOUT(TIMEOUT), .SPUR_CNT_W(SW)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   int errors = 0;
   int checks = 0;
   // reference model: phase 0 idle, 1 waiting for slave, 2 vector offered
   int         ph, wcnt, spur;
   logic [7:0] vec;
   logic       vld;
   logic       last_mack, last_sack, last_busy, last_vld;
   logic [7:0] last_vec;
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      ph = 0; wcnt = 0; spur = 0; vec = 8'h00; vld = 1'b0;
   endtask
   task automatic step();
      logic fire_s, fire_t, em;
      #1;
      fire_s = ph == 1 && bus.m_irq_valid && bus.m_slave_active && bus.s_irq_valid;
      fire_t = TO_EN && ph == 1 && bus.m_irq_valid && bus.m_slave_active && !bus.s_irq_valid && wcnt == TIMEOUT - 1;
      em = (ph == 0 && bus.m_irq_valid && bus.cpu_if && !bus.m_slave_active) || fire_s || fire_t;
      check("m_ack", bus.m_irq_ack, em);
      check("s_ack", bus.s_irq_ack, fire_s);
      check("busy", bus.busy, ph != 0);
      check("valid", bus.cpu_int_valid, vld);
      check("vector", bus.cpu_int_vector, vec);
      check("spur_cnt", bus.spurious_cnt, spur);
      last_mack = bus.m_irq_ack; last_sack = bus.s_irq_ack; last_busy = bus.busy;
      last_vld = bus.cpu_int_valid; last_vec = bus.cpu_int_vector;
      if (ph == 0) begin
         if (bus.m_irq_valid && bus.cpu_if) begin
            if (bus.m_slave_active) begin ph = 1; wcnt = 0; end
            else begin ph = 2; vld = 1'b1; vec = bus.m_irq_data; end
         end
      end else if (ph == 1) begin
         if (!bus.m_irq_valid || !bus.m_slave_active) ph = 0;
         else if (fire_s) begin ph = 2; vld = 1'b1; vec = bus.s_irq_data; end
         else if (fire_t) begin
            ph = 2; vld = 1'b1; vec = {bus.s_irq_data[7:3], 3'b111};
            if (spur < (1 << SW) - 1) spur++;
         end else wcnt++;
      end else if (bus.cpu_int_ready) begin
         ph = 0; vld = 1'b0;
      end
      @(negedge clk);
   endtask
   task automatic drive(input logic mv, input logic [7:0] md, input logic msa, input logic sv,
                        input logic [7:0] sd, input logic cif, input logic rdy);
      bus.m_irq_valid = mv; bus.m_irq_data = md; bus.m_slave_active = msa;
      bus.s_irq_valid = sv; bus.s_irq_data = sd; bus.cpu_if = cif; bus.cpu_int_ready = rdy;
      step();
   endtask
   initial begin
      int k;
      logic any_ack, any_busy, vec_moved;
      logic mv, msa;
      resetn = 1'b0;
      bus.m_irq_valid = 0; bus.m_irq_data = 0; bus.m_slave_active = 0;
      bus.s_irq_valid = 0; bus.s_irq_data = 0; bus.cpu_if = 0; bus.cpu_int_ready = 0;
      model_reset();
      @(negedge clk);
      check("rst_valid", bus.cpu_int_valid, 0);
      check("rst_vector", bus.cpu_int_vector, 8'h00);
      check("rst_busy", bus.busy, 0);
      check("rst_spur", bus.spurious_cnt, 0);
      resetn = 1'b1;
      // master-only request
      drive(1, 8'h0B, 0, 0, 8'h00, 1, 1);
      check("t1_mack", last_mack, 1);
      check("t1_sack", last_sack, 0);
      drive(0, 8'h00, 0, 0, 8'h00, 1, 1);
      check("t1_valid", last_vld, 1);
      check("t1_vec", last_vec, 8'h0B);
      drive(0, 8'h00, 0, 0, 8'h00, 1, 1);
      check("t1_idle", last_busy, 0);
      // cascade answered by the slave three cycles later
      drive(1, 8'h00, 1, 0, 8'h00, 1, 0);
      for (int i = 0; i < 3; i++) drive(1, 8'h00, 1, 0, 8'h00, 1, 0);
      drive(1, 8'h00, 1, 1, 8'h72, 1, 0);
      check("t2_mack", last_mack, 1);
      check("t2_sack", last_sack, 1);
      drive(0, 8'h00, 0, 0, 8'h00, 1, 1);
      check("t2_vec", last_vec, 8'h72);
      drive(0, 8'h00, 0, 0, 8'h00, 1, 1);
      // slave never answers
      drive(1, 8'h00, 1, 0, 8'h70, 1, 1);
      k = -1;
      for (int i = 0; i < TIMEOUT; i++) begin
         drive(1, 8'h00, 1, 0, 8'h70, 1, 1);
         if (last_mack && k < 0) k = i;
         check("t3_no_sack", last_sack, 0);
      end
      check("t3_ack_cycle", k, TO_EN ? TIMEOUT - 1 : -1);
      drive(0, 8'h00, 0, 0, 8'h70, 1, 1);
      check("t3_vec", last_vec, TO_EN ? 8'h77 : 8'h72);
      check("t3_spur", bus.spurious_cnt, TO_EN ? 1 : 0);
      drive(0, 8'h00, 0, 0, 8'h00, 1, 1);
      check("t3_idle", last_busy, 0);
      // interrupts disabled holds the request off
      any_ack = 0; any_busy = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 8'h21, 0, 0, 8'h00, 0, 1);
         any_ack |= last_mack; any_busy |= last_busy;
      end
      check("t4_no_ack", any_ack, 0);
      check("t4_not_busy", any_busy, 0);
      drive(1, 8'h21, 0, 0, 8'h00, 1, 0);
      check("t4_ack", last_mack, 1);
      // CPU stalls while the master data wanders
      any_ack = 0; vec_moved = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'($urandom), 0, 0, 8'($urandom), 1'($urandom), 0);
         any_ack |= last_mack | last_sack;
         vec_moved |= last_vec != 8'h21 || !last_vld;
      end
      check("t5_no_ack", any_ack, 0);
      check("t5_vec_stable", vec_moved, 0);
      drive(0, 8'h00, 0, 0, 8'h00, 1, 1);
      check("t5_vec", last_vec, 8'h21);
      drive(0, 8'h00, 0, 0, 8'h00, 1, 1);
      check("t5_done", last_vld, 0);
      // master withdraws while waiting for the slave
      drive(1, 8'h00, 1, 0, 8'h00, 1, 0);
      drive(1, 8'h00, 1, 0, 8'h00, 1, 0);
      drive(0, 8'h00, 1, 0, 8'h00, 1, 0);
      check("t6_no_ack", last_mack | last_sack, 0);
      drive(0, 8'h00, 0, 0, 8'h00, 1, 0);
      check("t6_idle", last_busy, 0);
      // asynchronous reset while a vector is offered
      drive(1, 8'h5A, 0, 0, 8'h00, 1, 0);
      drive(0, 8'h00, 0, 0, 8'h00, 1, 0);
      check("t6_present", last_vld, 1);
      resetn = 1'b0;
      #1;
      check("t6_rst_valid", bus.cpu_int_valid, 0);
      check("t6_rst_busy", bus.busy, 0);
      check("t6_rst_vector", bus.cpu_int_vector, 8'h00);
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      // sticky random traffic so long slave waits occur
      mv = 0; msa = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) mv = ~mv;
         if ($urandom_range(0, 7) == 0) msa = ~msa;
         drive(mv, 8'($urandom), msa, $urandom_range(0, 11) == 0, 8'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
